// File: rtl/mem_arbiter.sv
// Arbiter and sequencer for the shared fixed-latency memory used by fetch and load/store.
// One transaction at a time: issue, hold for LAT cycles, then a one-cycle done pulse.
module mem_arbiter #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_rdata,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  // state | meaning
  // IDLE  | sample requests, issue granted one (mem_en this cycle)
  // WAIT  | count down memory latency, capture read data on terminal count
  // RESP  | pulse done for the granted requester, update arbitration history
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        gnt_data, gnt_wr, last_was_data;
  logic [15:0] lat_addr, lat_wdata;
  logic        d_one, d_both, issue, issue_data;
  logic        req_held, err_set;
  logic [15:0] addr_now;

  always_comb begin
    d_one      = d_rd ^ d_wr;
    d_both     = d_rd & d_wr;
    // Data wins unless fetch is also pending and data had the previous grant.
    issue_data = d_one && (!if_req || !last_was_data);
    issue      = (state == IDLE) && (issue_data || if_req);
    state_nxt  = state;
    cnt_nxt    = cnt;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 16'h0000;
    mem_wdata  = 16'h0000;
    if_done    = 1'b0;
    d_done     = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          mem_en = 1'b1;
          if (issue_data) begin
            mem_wr    = d_wr;
            mem_addr  = d_addr;
            mem_wdata = d_wr ? d_wdata : 16'h0000;
          end else begin
            mem_addr = if_addr;
          end
          cnt_nxt   = LAT_M1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        if_done   = !gnt_data;
        d_done    = gnt_data;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_held = gnt_data ? (gnt_wr ? d_wr : d_rd) : if_req;
    addr_now = gnt_data ? d_addr : if_addr;
    err_set  = ((state == IDLE) && d_both) ||
               ((state != IDLE) && !req_held) ||
               ((state == WAIT) && ((addr_now != lat_addr) ||
                                    (gnt_wr && (d_wdata != lat_wdata))));
    stall    = ((d_rd | d_wr) & ~d_done) | (if_req & ~if_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      gnt_data      <= 1'b0;
      gnt_wr        <= 1'b0;
      last_was_data <= 1'b0;
      lat_addr      <= 16'h0000;
      lat_wdata     <= 16'h0000;
      if_rdata      <= 16'h0000;
      d_rdata       <= 16'h0000;
      err           <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (err_set) err <= 1'b1;
      if (issue) begin
        gnt_data  <= issue_data;
        gnt_wr    <= issue_data & d_wr;
        lat_addr  <= mem_addr;
        lat_wdata <= d_wdata;
      end
      if ((state == WAIT) && (cnt == 4'd0) && !gnt_wr) begin
        if (gnt_data) d_rdata  <= mem_rdata;
        else          if_rdata <= mem_rdata;
      end
      if (state == RESP) last_was_data <= gnt_data;
    end
  end

endmodule
